seg7_bcd_display: RTL

- Output stage fed directly by the 16-bit accumulator sum.
- On a load strobe, captures the unsigned binary value and converts it to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Drives a 4-digit, time-multiplexed, common-anode 7-segment display.
- Values above 9999 light an overflow flag and show dashes on all four digits.

---
 rtl/seg7_bcd_display.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seg7_bcd_display.sv
// seg7_bcd_display
//   Output stage for the 16-bit accumulator sum. A load strobe captures the
//   unsigned value, a shift-add-3 (double-dabble) engine converts it to BCD
//   one bit per clock, and the result drives a 4-digit, time-multiplexed,
//   common-anode 7-segment display. Values above 9999 show four dashes.
//
// Ports
//   c      : system clock, rising edge
//   clr_n  : asynchronous active-low reset
//   value  : [15:0] unsigned binary value to display
//   load   : start-conversion strobe, honoured only while idle
//   busy   : high while a conversion is in progress (16 clocks)
//   done   : one-clock pulse after new digits have been latched
//   ovf    : latched value is greater than 9999
//   an     : [3:0] digit enables, active-low, an[0] = ones digit
//   seg    : [6:0] segments g..a, active-low
module seg7_bcd_display #(
  parameter int REFRESH_BITS = 16,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        c,
  input  logic        clr_n,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t                  state, state_nx;
  logic [15:0]             shreg, shreg_nx;
  logic [19:0]             bcd, bcd_adj, bcd_nx;
  logic [4:0]              iter;
  logic [3:0]              disp [4];
  logic [REFRESH_BITS-1:0] scan;
  logic                    last_iter;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    blank;

  // The 16th iteration is the one that starts with iter == 15.
  assign last_iter = (state == CONV) && (iter == 5'd15);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load)      state_nx = CONV;
      CONV:    if (last_iter) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
  end

  // ------------------------------------------------- double-dabble step
  // Correct every nibble that would overflow past 9 after doubling, then
  // shift the whole {bcd, shreg} chain left by one.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign {bcd_nx, shreg_nx} = {bcd_adj[18:0], shreg, 1'b0};

  // ------------------------------------------------------------ datapath
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  // NOTE: the small digit array is reset along with everything else, since
  // the display must show "0" straight out of reset.
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      shreg <= '0;
      bcd   <= '0;
      iter  <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < 4; i++) disp[i] <= '0;
    end else begin
      done <= last_iter;
      if (state == IDLE) begin
        if (load) begin
          shreg <= value;
          bcd   <= '0;
          iter  <= '0;
        end
      end else begin
        shreg <= shreg_nx;
        bcd   <= bcd_nx;
        iter  <= iter + 5'd1;
        if (last_iter) begin
          for (int i = 0; i < 4; i++) disp[i] <= bcd_nx[4*i +: 4];
          // Any ten-thousands digit means the value exceeds 9999.
          ovf <= (bcd_nx[19:16] != 4'd0);
        end
      end
    end
  end

  // ------------------------------------------------------- scan counter
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) scan <= '0;
    else        scan <= scan + 1'b1;
  end

  assign sel   = scan[REFRESH_BITS-1 -: 2];
  assign an    = ~(4'b0001 << sel);
  assign digit = disp[sel];

  // A digit is a leading zero when it and every more-significant digit is 0.
  always_comb begin
    blank = 1'b0;
    case (sel)
      2'd3:    blank = (disp[3] == 4'd0);
      2'd2:    blank = (disp[3] == 4'd0) && (disp[2] == 4'd0);
      2'd1:    blank = (disp[3] == 4'd0) && (disp[2] == 4'd0) && (disp[1] == 4'd0);
      default: blank = 1'b0;
    endcase
  end

  always_comb begin
    seg = SEG_BLANK;
    if (ovf) begin
      seg = SEG_DASH;
    end else if (!(BLANK_LZ && blank)) begin
      case (digit)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule
